reorder_buffer: RTL and testbench

//  Circular reorder buffer for the out-of-order core; the producer side of the

---
 rtl/reorder_buffer.sv | 179 +++++++++++++++++
 tb/tb_reorder_buffer.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates ids at issue, captures CDB results,
// answers operand-readiness queries and retires in order with mispredict flush.
module reorder_buffer #(
    parameter int ROBSZ = 16,
    parameter int ROBBW = 5,
    parameter int REGBW = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             alloc_valid,
    input  logic [REGBW-1:0] alloc_rd,
    output logic [ROBBW-1:0] alloc_id,
    output logic             full,
    input  logic             wb_valid,
    input  logic [ROBBW-1:0] wb_id,
    input  logic [31:0]      wb_val,
    input  logic             wb_mispredict,
    input  logic [31:0]      wb_target,
    input  logic [ROBBW-1:0] id1,
    input  logic [ROBBW-1:0] id2,
    output logic             id1_ready,
    output logic             id2_ready,
    output logic [31:0]      id1_val,
    output logic [31:0]      id2_val,
    output logic             flag_ROB,
    output logic [REGBW-1:0] rd_ROB,
    output logic [31:0]      id_ROB,
    output logic [31:0]      val_ROB,
    output logic             flush,
    output logic [31:0]      flush_pc
);
    localparam int IW = (ROBSZ > 1) ? $clog2(ROBSZ) : 1;
    localparam int CW = $clog2(ROBSZ + 1);
    localparam logic [IW-1:0]    LAST  = IW'(ROBSZ - 1);
    localparam logic [ROBBW-1:0] MAXID = ROBBW'(ROBSZ);

    logic             busy_q  [ROBSZ];
    logic             ready_q [ROBSZ];
    logic             misp_q  [ROBSZ];
    logic [REGBW-1:0] rd_q    [ROBSZ];
    logic [31:0]      val_q   [ROBSZ];
    logic [31:0]      tgt_q   [ROBSZ];

    logic [IW-1:0]    head_q, head_d, tail_q, tail_d;
    logic [CW-1:0]    count_q, count_d;

    logic             flag_q, flush_q;
    logic [REGBW-1:0] crd_q;
    logic [31:0]      cid_q, cval_q, fpc_q;

    logic             do_alloc, do_commit, do_flush, wb_hit;
    logic [IW-1:0]    wb_idx;

    logic [ROBBW-1:0] qid  [2];
    logic             qrdy [2];
    logic [31:0]      qval [2];
    logic [IW-1:0]    qidx [2];

    assign full     = (count_q == CW'(ROBSZ));
    assign alloc_id = ROBBW'(tail_q) + ROBBW'(1);

    assign wb_idx = IW'(wb_id - ROBBW'(1));
    assign wb_hit = rdy && wb_valid && (wb_id != '0) &&
                    (wb_id <= MAXID) && busy_q[wb_idx];

    assign qid[0]    = id1;
    assign qid[1]    = id2;
    assign id1_ready = qrdy[0];
    assign id2_ready = qrdy[1];
    assign id1_val   = qval[0];
    assign id2_val   = qval[1];

    // A result on the CDB this cycle wins over the stored slot state.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            qrdy[p] = 1'b0;
            qval[p] = '0;
            qidx[p] = IW'(qid[p] - ROBBW'(1));
            if (qid[p] != '0) begin
                if (wb_valid && (wb_id == qid[p])) begin
                    qrdy[p] = 1'b1;
                    qval[p] = wb_val;
                end else if (qid[p] <= MAXID) begin
                    qrdy[p] = busy_q[qidx[p]] && ready_q[qidx[p]];
                    qval[p] = val_q[qidx[p]];
                end
            end
        end
    end

    always_comb begin
        do_alloc  = rdy && alloc_valid && !full;
        do_commit = rdy && busy_q[head_q] && ready_q[head_q];
        do_flush  = do_commit && misp_q[head_q];
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        if (do_flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            if (do_commit)
                head_d = (head_q == LAST) ? '0 : head_q + IW'(1);
            if (do_alloc)
                tail_d = (tail_q == LAST) ? '0 : tail_q + IW'(1);
            count_d = count_q + CW'(do_alloc) - CW'(do_commit);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ROBSZ; i++) begin
                busy_q[i]  <= 1'b0;
                ready_q[i] <= 1'b0;
                misp_q[i]  <= 1'b0;
                rd_q[i]    <= '0;
                val_q[i]   <= '0;
                tgt_q[i]   <= '0;
            end
        end else if (do_flush) begin
            for (int i = 0; i < ROBSZ; i++)
                busy_q[i] <= 1'b0;
        end else begin
            if (do_commit)
                busy_q[head_q] <= 1'b0;
            if (do_alloc) begin
                busy_q[tail_q]  <= 1'b1;
                ready_q[tail_q] <= 1'b0;
                misp_q[tail_q]  <= 1'b0;
                rd_q[tail_q]    <= alloc_rd;
            end
            if (wb_hit) begin
                ready_q[wb_idx] <= 1'b1;
                val_q[wb_idx]   <= wb_val;
                misp_q[wb_idx]  <= wb_mispredict;
                tgt_q[wb_idx]   <= wb_target;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            flag_q  <= 1'b0;
            crd_q   <= '0;
            cid_q   <= '0;
            cval_q  <= '0;
            flush_q <= 1'b0;
            fpc_q   <= '0;
        end else if (rdy) begin
            flag_q  <= do_commit && (rd_q[head_q] != '0);
            crd_q   <= do_commit ? rd_q[head_q] : '0;
            cid_q   <= do_commit ? 32'(head_q) + 32'd1 : '0;
            cval_q  <= do_commit ? val_q[head_q] : '0;
            flush_q <= do_flush;
            fpc_q   <= do_flush ? tgt_q[head_q] : '0;
        end
    end

    assign flag_ROB = flag_q;
    assign rd_ROB   = crd_q;
    assign id_ROB   = cid_q;
    assign val_ROB  = cval_q;
    assign flush    = flush_q;
    assign flush_pc = fpc_q;
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed table, hand sequences, and random
// traffic against a queue-based program-order model.
module tb_reorder_buffer;
    logic        clk = 1'b0;
    logic        rst, rdy, alloc_valid, wb_valid, wb_mispredict;
    logic [4:0]  alloc_rd, alloc_id, wb_id, id1, id2, rd_ROB;
    logic        full, id1_ready, id2_ready, flag_ROB, flush;
    logic [31:0] wb_val, wb_target, id1_val, id2_val;
    logic [31:0] id_ROB, val_ROB, flush_pc;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reorder_buffer dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd),
        .alloc_id(alloc_id), .full(full),
        .wb_valid(wb_valid), .wb_id(wb_id), .wb_val(wb_val),
        .wb_mispredict(wb_mispredict), .wb_target(wb_target),
        .id1(id1), .id2(id2),
        .id1_ready(id1_ready), .id2_ready(id2_ready),
        .id1_val(id1_val), .id2_val(id2_val),
        .flag_ROB(flag_ROB), .rd_ROB(rd_ROB), .id_ROB(id_ROB),
        .val_ROB(val_ROB), .flush(flush), .flush_pc(flush_pc)
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: entries in program order, oldest first.
    typedef struct {
        int id; int rd; bit rdy; int val; bit mis; int tgt;
    } ent_t;
    ent_t mq[$];
    int   nxt;
    bit   e_flag, e_fl;
    int   e_rd, e_id, e_val, e_fpc;

    task automatic m_reset();
        mq.delete();
        nxt = 1;
        e_flag = 0; e_rd = 0; e_id = 0; e_val = 0; e_fl = 0; e_fpc = 0;
    endtask

    function automatic void m_query(input int id, input bit wv, input int wid,
                                    input int wval, output bit r,
                                    output int v, output bit vk);
        r = 0; v = 0; vk = 1;
        if (id == 0) return;
        if (wv && wid == id) begin
            r = 1; v = wval; return;
        end
        vk = 0;
        foreach (mq[i])
            if (mq[i].id == id) begin
                r = mq[i].rdy; v = mq[i].val; vk = mq[i].rdy;
            end
    endfunction

    task automatic m_step(input bit r, input bit av, input int ard,
                          input bit wv, input int wid, input int wval,
                          input bit wm, input int wt);
        bit com, was_full;
        ent_t e;
        if (!r) return;
        was_full = (mq.size() == 16);
        com = (mq.size() > 0) && mq[0].rdy;
        e_flag = 0; e_rd = 0; e_id = 0; e_val = 0; e_fl = 0; e_fpc = 0;
        if (com) begin
            e_flag = (mq[0].rd != 0);
            e_rd = mq[0].rd; e_id = mq[0].id; e_val = mq[0].val;
            if (mq[0].mis) begin
                e_fl = 1; e_fpc = mq[0].tgt;
                mq.delete(); nxt = 1;
                return;
            end
            void'(mq.pop_front());
        end
        if (wv && wid != 0)
            foreach (mq[i])
                if (mq[i].id == wid) begin
                    mq[i].rdy = 1; mq[i].val = wval;
                    mq[i].mis = wm; mq[i].tgt = wt;
                end
        if (av && !was_full) begin
            e.id = nxt; e.rd = ard; e.rdy = 0; e.val = 0; e.mis = 0; e.tgt = 0;
            mq.push_back(e);
            nxt = nxt % 16 + 1;
        end
    endtask

    task automatic drive(input bit r, input bit av, input int ard,
                         input bit wv, input int wid, input int wval,
                         input bit wm, input int wt, input int a, input int b);
        rdy = r; alloc_valid = av; alloc_rd = ard[4:0];
        wb_valid = wv; wb_id = wid[4:0]; wb_val = wval;
        wb_mispredict = wm; wb_target = wt;
        id1 = a[4:0]; id2 = b[4:0];
    endtask

    task automatic cyc(input bit r, input bit av, input int ard,
                       input bit wv, input int wid, input int wval,
                       input bit wm, input int wt, input int a, input int b);
        bit er; int ev; bit vk;
        @(negedge clk);
        drive(r, av, ard, wv, wid, wval, wm, wt, a, b);
        #1;
        chk("alloc_id", 32'(alloc_id), nxt);
        chk("full", 32'(full), 32'(mq.size() == 16));
        m_query(a, wv, wid, wval, er, ev, vk);
        chk("id1_ready", 32'(id1_ready), 32'(er));
        if (vk) chk("id1_val", id1_val, ev);
        m_query(b, wv, wid, wval, er, ev, vk);
        chk("id2_ready", 32'(id2_ready), 32'(er));
        if (vk) chk("id2_val", id2_val, ev);
        @(posedge clk);
        m_step(r, av, ard, wv, wid, wval, wm, wt);
        #1;
        chk("flag_ROB", 32'(flag_ROB), 32'(e_flag));
        chk("rd_ROB", 32'(rd_ROB), e_rd);
        chk("id_ROB", id_ROB, e_id);
        chk("val_ROB", val_ROB, e_val);
        chk("flush", 32'(flush), 32'(e_fl));
        chk("flush_pc", flush_pc, e_fpc);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_reset();
        @(negedge clk);
        rst = 1;
    endtask

    typedef struct {
        bit av; int ard; bit wv; int wid; int wval; int q1;
        bit e_qr; int e_qv; int e_aid;
        bit e_flag; int e_rd; int e_id; int e_val;
    } vec_t;
    vec_t tbl[10];

    initial begin
        bit r, av, wv, wm;
        int ard, wid, wval, wt, a, b;

        tbl[0] = '{1, 3, 0, 0, 0,        0, 0, 0,        1, 0, 0, 0, 0};
        tbl[1] = '{0, 0, 1, 1, 'hDEAD,   1, 1, 'hDEAD,   2, 0, 0, 0, 0};
        tbl[2] = '{0, 0, 0, 0, 0,        1, 1, 'hDEAD,   2, 1, 3, 1, 'hDEAD};
        tbl[3] = '{1, 5, 0, 0, 0,        0, 0, 0,        2, 0, 0, 0, 0};
        tbl[4] = '{1, 0, 0, 0, 0,        2, 0, 0,        3, 0, 0, 0, 0};
        tbl[5] = '{0, 0, 1, 3, 'h33,     3, 1, 'h33,     4, 0, 0, 0, 0};
        tbl[6] = '{0, 0, 1, 2, 'h22,     3, 1, 'h33,     4, 0, 0, 0, 0};
        tbl[7] = '{0, 0, 0, 0, 0,        2, 1, 'h22,     4, 1, 5, 2, 'h22};
        tbl[8] = '{0, 0, 0, 0, 0,        0, 0, 0,        4, 0, 0, 3, 'h33};
        tbl[9] = '{0, 0, 1, 5, 7,        5, 1, 7,        4, 0, 0, 0, 0};

        rst = 0;
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        m_reset();
        repeat (2) @(negedge clk);
        #1;
        chk("rst_flag", 32'(flag_ROB), 0);
        chk("rst_flush", 32'(flush), 0);
        chk("rst_id_ROB", id_ROB, 0);
        chk("rst_alloc_id", 32'(alloc_id), 1);
        chk("rst_full", 32'(full), 0);
        @(negedge clk);
        rst = 1;

        foreach (tbl[k]) begin
            @(negedge clk);
            drive(1, tbl[k].av, tbl[k].ard, tbl[k].wv, tbl[k].wid,
                  tbl[k].wval, 0, 0, tbl[k].q1, 0);
            #1;
            chk($sformatf("tbl%0d_alloc_id", k), 32'(alloc_id), tbl[k].e_aid);
            chk($sformatf("tbl%0d_q1_rdy", k), 32'(id1_ready), 32'(tbl[k].e_qr));
            if (tbl[k].e_qr || tbl[k].q1 == 0)
                chk($sformatf("tbl%0d_q1_val", k), id1_val, tbl[k].e_qv);
            chk($sformatf("tbl%0d_q2_rdy", k), 32'(id2_ready), 0);
            chk($sformatf("tbl%0d_q2_val", k), id2_val, 0);
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_flag", k), 32'(flag_ROB), 32'(tbl[k].e_flag));
            chk($sformatf("tbl%0d_rd", k), 32'(rd_ROB), tbl[k].e_rd);
            chk($sformatf("tbl%0d_id", k), id_ROB, tbl[k].e_id);
            chk($sformatf("tbl%0d_val", k), val_ROB, tbl[k].e_val);
        end

        // Fill, overflow, commit-while-full, wrap.
        do_reset();
        for (int i = 0; i < 16; i++) cyc(1, 1, i + 1, 0, 0, 0, 0, 0, i + 1, 0);
        chk("fill_full", 32'(full), 1);
        chk("fill_alloc_id_wrap", 32'(alloc_id), 1);
        cyc(1, 1, 9, 0, 0, 0, 0, 0, 16, 0);
        chk("overflow_full", 32'(full), 1);
        cyc(1, 0, 0, 1, 1, 'h11, 0, 0, 1, 2);
        cyc(1, 1, 7, 0, 0, 0, 0, 0, 1, 0);
        chk("commit_full_clear", 32'(full), 0);
        chk("commit_alloc_id", 32'(alloc_id), 1);
        cyc(1, 1, 7, 0, 0, 0, 0, 0, 0, 0);
        chk("realloc_full", 32'(full), 1);
        chk("realloc_alloc_id", 32'(alloc_id), 2);

        // Asynchronous reset in the middle of a commit.
        cyc(1, 0, 0, 1, 2, 'h22, 0, 0, 0, 0);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("pre_rst_flag", 32'(flag_ROB), 1);
        #2 rst = 0;
        #1;
        chk("mid_rst_flag", 32'(flag_ROB), 0);
        chk("mid_rst_rd", 32'(rd_ROB), 0);
        chk("mid_rst_id", id_ROB, 0);
        chk("mid_rst_val", val_ROB, 0);
        chk("mid_rst_flush", 32'(flush), 0);
        chk("mid_rst_alloc_id", 32'(alloc_id), 1);
        chk("mid_rst_full", 32'(full), 0);
        m_reset();
        @(negedge clk);
        rst = 1;
        #1;
        chk("post_rst_alloc_id", 32'(alloc_id), 1);
        chk("post_rst_full", 32'(full), 0);

        // Mispredict retirement flushes everything younger.
        for (int i = 0; i < 4; i++) cyc(1, 1, i + 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 0, 0, 1, 1, 'hAA, 1, 'h100, 1, 0);
        cyc(1, 1, 6, 1, 2, 'hBB, 0, 0, 2, 0);
        chk("misp_flag", 32'(flag_ROB), 1);
        chk("misp_flush", 32'(flush), 1);
        chk("misp_flush_pc", flush_pc, 'h100);
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("misp_after_flush", 32'(flush), 0);
        chk("misp_after_full", 32'(full), 0);
        chk("misp_after_alloc_id", 32'(alloc_id), 1);
        for (int i = 2; i <= 4; i++) begin
            cyc(1, 0, 0, 1, i, i, 0, 0, i, 0);
            chk($sformatf("misp_no_commit_%0d", i), 32'(flag_ROB), 0);
        end
        idle(2);
        chk("misp_stale_id", id_ROB, 0);

        // Randomized traffic.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            r    = ($urandom_range(0, 9) != 0);
            av   = ($urandom_range(0, 2) != 0);
            ard  = $urandom_range(0, 31);
            wv   = ($urandom_range(0, 1) != 0);
            wval = $urandom;
            wm   = ($urandom_range(0, 19) == 0);
            wt   = $urandom;
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                wid = mq[$urandom_range(0, mq.size() - 1)].id;
            else
                wid = $urandom_range(0, 31);
            foreach (mq[i])
                if (mq[i].id == wid && mq[i].rdy) wv = 0;
            a = ($urandom_range(0, 3) == 0) ? wid : $urandom_range(0, 17);
            b = $urandom_range(0, 17);
            cyc(r, av, ard, wv, wid, wval, wm, wt, a, b);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
